// File: rtl/k_mult_div_unit.sv
// k_mult_div_unit: iterative MULT/MULTU/DIV/DIVU engine holding the architectural
// HI/LO registers. Runs one bit per cycle for WIDTH cycles, then a sign-fix cycle.
// MTHI/MTLO write HI/LO directly from IDLE without occupying the unit.
module k_mult_div_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             K_start,
    input  logic [2:0]       K_op,
    input  logic [WIDTH-1:0] K_in1,
    input  logic [WIDTH-1:0] K_in2,
    output logic             K_busy,
    output logic             K_done,
    output logic [WIDTH-1:0] K_hi,
    output logic [WIDTH-1:0] K_lo
);

    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_FIX  = 2'd2
    } state_t;

    state_t               state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic                 is_div_q, is_div_d;
    logic                 neg_a_q, neg_a_d;    // product / quotient must be negated
    logic                 neg_r_q, neg_r_d;    // remainder must be negated
    logic                 dz_q, dz_d;          // divisor was zero at latch time
    logic [WIDTH-1:0]     raw_q, raw_d;        // dividend as presented, for divide-by-zero HI
    logic [WIDTH-1:0]     opnd_q, opnd_d;      // multiplicand or divisor magnitude
    logic [2*WIDTH-1:0]   acc_q, acc_d;        // {upper, lower}: product, or {remainder, dividend/quotient}
    logic [WIDTH-1:0]     hi_q, hi_d;
    logic [WIDTH-1:0]     lo_q, lo_d;
    logic                 done_q, done_d;

    // Operand decode at latch time
    logic                 op_signed, op_div;
    logic                 sgn1, sgn2;
    logic [WIDTH-1:0]     mag1, mag2;

    // One-iteration datapaths
    logic [WIDTH:0]       mul_sum;
    logic [WIDTH:0]       div_shift;
    logic [WIDTH:0]       div_diff;

    // Sign-fixed results
    logic [2*WIDTH-1:0]   prod_fix;
    logic [WIDTH-1:0]     quo_fix;
    logic [WIDTH-1:0]     rem_fix;

    assign op_signed = ~K_op[0];
    assign op_div    = K_op[1];
    assign sgn1      = op_signed & K_in1[WIDTH-1];
    assign sgn2      = op_signed & K_in2[WIDTH-1];
    assign mag1      = sgn1 ? (~K_in1 + 1'b1) : K_in1;
    assign mag2      = sgn2 ? (~K_in2 + 1'b1) : K_in2;

    // Multiply: add multiplicand into the upper half when the current multiplier bit is set
    assign mul_sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, (acc_q[0] ? opnd_q : {WIDTH{1'b0}})};
    // Divide: bring the next dividend bit into the partial remainder and trial-subtract
    assign div_shift = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
    assign div_diff  = div_shift - {1'b0, opnd_q};

    assign prod_fix  = neg_a_q ? (~acc_q + 1'b1) : acc_q;
    assign quo_fix   = neg_a_q ? (~acc_q[WIDTH-1:0] + 1'b1) : acc_q[WIDTH-1:0];
    assign rem_fix   = neg_r_q ? (~acc_q[2*WIDTH-1:WIDTH] + 1'b1) : acc_q[2*WIDTH-1:WIDTH];

    // Next-state, iteration datapath and HI/LO update
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        is_div_d = is_div_q;
        neg_a_d  = neg_a_q;
        neg_r_d  = neg_r_q;
        dz_d     = dz_q;
        raw_d    = raw_q;
        opnd_d   = opnd_q;
        acc_d    = acc_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        done_d   = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (K_start) begin
                    if (!K_op[2]) begin
                        state_d  = S_CALC;
                        cnt_d    = '0;
                        is_div_d = op_div;
                        neg_a_d  = sgn1 ^ sgn2;
                        neg_r_d  = op_div & sgn1;
                        dz_d     = op_div & (K_in2 == '0);
                        raw_d    = K_in1;
                        if (op_div) begin
                            opnd_d = mag2;
                            acc_d  = {{WIDTH{1'b0}}, mag1};
                        end else begin
                            opnd_d = mag1;
                            acc_d  = {{WIDTH{1'b0}}, mag2};
                        end
                    end else if (!K_op[1]) begin
                        if (K_op[0]) begin
                            lo_d = K_in1;
                        end else begin
                            hi_d = K_in1;
                        end
                    end
                end
            end
            S_CALC: begin
                if (is_div_q) begin
                    // Borrow means the trial subtraction failed: restore and shift in a 0
                    acc_d = {(div_diff[WIDTH] ? div_shift[WIDTH-1:0] : div_diff[WIDTH-1:0]),
                             acc_q[WIDTH-2:0], ~div_diff[WIDTH]};
                end else begin
                    acc_d = {mul_sum, acc_q[WIDTH-1:1]};
                end
                if (cnt_q == CNT_W'(WIDTH - 1)) begin
                    state_d = S_FIX;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_FIX: begin
                if (!is_div_q) begin
                    hi_d = prod_fix[2*WIDTH-1:WIDTH];
                    lo_d = prod_fix[WIDTH-1:0];
                end else if (dz_q) begin
                    hi_d = raw_q;
                    lo_d = {WIDTH{1'b1}};
                end else begin
                    hi_d = rem_fix;
                    lo_d = quo_fix;
                end
                done_d  = 1'b1;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and datapath registers; reset discards any in-flight operation
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            is_div_q <= 1'b0;
            neg_a_q  <= 1'b0;
            neg_r_q  <= 1'b0;
            dz_q     <= 1'b0;
            raw_q    <= '0;
            opnd_q   <= '0;
            acc_q    <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            is_div_q <= is_div_d;
            neg_a_q  <= neg_a_d;
            neg_r_q  <= neg_r_d;
            dz_q     <= dz_d;
            raw_q    <= raw_d;
            opnd_q   <= opnd_d;
            acc_q    <= acc_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            done_q   <= done_d;
        end
    end

    assign K_busy = (state_q != S_IDLE);
    assign K_done = done_q;
    assign K_hi   = hi_q;
    assign K_lo   = lo_q;

endmodule

// File: tb/tb_k_mult_div_unit.sv
// tb_k_mult_div_unit: directed scenarios plus randomized operations, all compared
// against an arithmetic reference model of HI/LO.
module tb_k_mult_div_unit;

    localparam logic [2:0] OP_MULT  = 3'b000;
    localparam logic [2:0] OP_MULTU = 3'b001;
    localparam logic [2:0] OP_DIV   = 3'b010;
    localparam logic [2:0] OP_DIVU  = 3'b011;
    localparam logic [2:0] OP_MTHI  = 3'b100;
    localparam logic [2:0] OP_MTLO  = 3'b101;
    localparam int         LAT      = 33;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        K_start;
    logic [2:0]  K_op;
    logic [31:0] K_in1, K_in2;
    logic        K_busy, K_done;
    logic [31:0] K_hi, K_lo;

    int total = 0;
    int bad   = 0;

    logic [31:0] exp_hi, exp_lo;

    k_mult_div_unit #(.WIDTH(32)) dut (
        .clock   (clk),
        .reset_n (reset_n),
        .K_start (K_start),
        .K_op    (K_op),
        .K_in1   (K_in1),
        .K_in2   (K_in2),
        .K_busy  (K_busy),
        .K_done  (K_done),
        .K_hi    (K_hi),
        .K_lo    (K_lo)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        total++;
        if (obs !== expv) begin
            bad++;
            $display("FAIL %s: got=%h want=%h", tag, obs, expv);
        end
    endtask

    // Architectural result of a MULT/DIV-class op, from plain 64-bit arithmetic
    function automatic void ref_md(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                                   output logic [31:0] hi, output logic [31:0] lo);
        longint      sa, sb, q, r;
        logic [63:0] p;
        sa = $signed(a);
        sb = $signed(b);
        hi = '0;
        lo = '0;
        case (op)
            OP_MULT: begin
                p  = 64'(sa * sb);
                hi = p[63:32];
                lo = p[31:0];
            end
            OP_MULTU: begin
                p  = {32'b0, a} * {32'b0, b};
                hi = p[63:32];
                lo = p[31:0];
            end
            OP_DIV: begin
                if (b == 0) begin
                    hi = a;
                    lo = 32'hFFFF_FFFF;
                end else begin
                    q  = sa / sb;
                    r  = sa % sb;
                    lo = 32'(q);
                    hi = 32'(r);
                end
            end
            default: begin
                if (b == 0) begin
                    hi = a;
                    lo = 32'hFFFF_FFFF;
                end else begin
                    lo = a / b;
                    hi = a % b;
                end
            end
        endcase
    endfunction

    function automatic logic [31:0] pick_operand();
        case ($urandom_range(0, 5))
            0:       return 32'h0;
            1:       return 32'h1;
            2:       return 32'hFFFF_FFFF;
            3:       return 32'h8000_0000;
            4:       return 32'($urandom_range(0, 20));
            default: return $urandom;
        endcase
    endfunction

    // Holds K_start for one rising edge, then scrambles operands to prove they are latched
    task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        K_start = 1'b1;
        K_op    = op;
        K_in1   = a;
        K_in2   = b;
        @(posedge clk);
        #1;
        K_start = 1'b0;
        K_in1   = $urandom;
        K_in2   = $urandom;
    endtask

    // Counts edges after the accept edge until K_done, bounded
    task automatic wait_done(output int n);
        n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (!K_done && n < 100);
    endtask

    task automatic run_md(input string tag, input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        int n;
        ref_md(op, a, b, exp_hi, exp_lo);
        @(negedge clk);
        issue(op, a, b);
        chk({tag, "_busy"}, K_busy, 1'b1);
        wait_done(n);
        chk({tag, "_lat"}, n, LAT);
        chk({tag, "_hi"}, K_hi, exp_hi);
        chk({tag, "_lo"}, K_lo, exp_lo);
        chk({tag, "_idle"}, K_busy, 1'b0);
        $display("op=%0d a=%h b=%h -> hi=%h lo=%h lat=%0d", op, a, b, K_hi, K_lo, n);
    endtask

    task automatic run_move(input string tag, input logic [2:0] op, input logic [31:0] a);
        if (op == OP_MTHI) exp_hi = a;
        if (op == OP_MTLO) exp_lo = a;
        @(negedge clk);
        issue(op, a, $urandom);
        chk({tag, "_busy"}, K_busy, 1'b0);
        chk({tag, "_done"}, K_done, 1'b0);
        chk({tag, "_hi"}, K_hi, exp_hi);
        chk({tag, "_lo"}, K_lo, exp_lo);
        $display("op=%0d a=%h -> hi=%h lo=%h", op, a, K_hi, K_lo);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got=timeout want=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int          n, pulses, first_at;
        logic [2:0]  op;
        logic [31:0] a, b;

        reset_n = 1'b0;
        K_start = 1'b0;
        K_op    = 3'b000;
        K_in1   = '0;
        K_in2   = '0;
        exp_hi  = '0;
        exp_lo  = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", K_busy, 1'b0);
        chk("rst_done", K_done, 1'b0);
        chk("rst_hi", K_hi, 32'h0);
        chk("rst_lo", K_lo, 32'h0);
        @(negedge clk);
        reset_n = 1'b1;

        // Idle moves on consecutive cycles
        run_move("mthi", OP_MTHI, 32'h0000_AAAA);
        issue(OP_MTLO, 32'h0000_5555, 32'h0);
        exp_lo = 32'h0000_5555;
        chk("mtlo_busy", K_busy, 1'b0);
        chk("mtlo_hi", K_hi, exp_hi);
        chk("mtlo_lo", K_lo, exp_lo);

        // Reset in the middle of a multiply
        @(negedge clk);
        issue(OP_MULTU, 32'd7, 32'd6);
        repeat (9) @(posedge clk);
        #3;
        reset_n = 1'b0;
        #1;
        exp_hi = '0;
        exp_lo = '0;
        chk("midrst_busy", K_busy, 1'b0);
        chk("midrst_hi", K_hi, exp_hi);
        chk("midrst_lo", K_lo, exp_lo);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        pulses = 0;
        for (int k = 0; k < 40; k++) begin
            @(posedge clk);
            #1;
            if (K_done) pulses++;
        end
        chk("midrst_nodone", pulses, 0);
        chk("midrst_lo_after", K_lo, exp_lo);
        run_md("multu7x6", OP_MULTU, 32'd7, 32'd6);

        // Directed arithmetic cases
        run_md("mult_m2x3", OP_MULT, 32'hFFFF_FFFE, 32'd3);
        run_md("multu_max", OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        run_md("div_m7_2", OP_DIV, 32'hFFFF_FFF9, 32'd2);
        run_md("divu_100_7", OP_DIVU, 32'd100, 32'd7);
        run_md("div_wrap", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
        run_md("divu_by0", OP_DIVU, 32'h0000_1234, 32'h0);
        run_md("div_by0_neg", OP_DIV, 32'hFFFF_FF00, 32'h0);

        // Requests while busy must be ignored
        ref_md(OP_MULT, 32'd5, 32'd5, exp_hi, exp_lo);
        @(negedge clk);
        issue(OP_MULT, 32'd5, 32'd5);
        pulses   = 0;
        first_at = 0;
        for (int k = 1; k <= 80; k++) begin
            @(negedge clk);
            if (k == 5) begin
                K_start = 1'b1;
                K_op    = OP_MTLO;
                K_in1   = 32'h0000_DEAD;
            end else if (k == 6) begin
                K_op    = OP_DIV;
                K_in1   = 32'd100;
                K_in2   = 32'd3;
            end else if (k == 7) begin
                K_start = 1'b0;
            end
            @(posedge clk);
            #1;
            if (K_done) begin
                pulses++;
                if (first_at == 0) first_at = k;
            end
        end
        chk("busyprot_lat", first_at, LAT);
        chk("busyprot_pulses", pulses, 1);
        chk("busyprot_hi", K_hi, exp_hi);
        chk("busyprot_lo", K_lo, exp_lo);
        $display("busy-protect mult 5x5 -> hi=%h lo=%h pulses=%0d", K_hi, K_lo, pulses);

        // Back-to-back: MULT issued in the K_done cycle of a DIV
        ref_md(OP_DIV, 32'd1000, 32'hFFFF_FFF6, exp_hi, exp_lo);
        @(negedge clk);
        issue(OP_DIV, 32'd1000, 32'hFFFF_FFF6);
        wait_done(n);
        chk("b2b_div_lat", n, LAT);
        chk("b2b_div_lo", K_lo, exp_lo);
        chk("b2b_div_hi", K_hi, exp_hi);
        ref_md(OP_MULT, 32'h0001_0000, 32'hFFFF_0000, exp_hi, exp_lo);
        issue(OP_MULT, 32'h0001_0000, 32'hFFFF_0000);
        chk("b2b_mult_busy", K_busy, 1'b1);
        wait_done(n);
        chk("b2b_mult_lat", n, LAT);
        chk("b2b_mult_hi", K_hi, exp_hi);
        chk("b2b_mult_lo", K_lo, exp_lo);
        $display("back-to-back mult -> hi=%h lo=%h lat=%0d", K_hi, K_lo, n);

        // Randomized mix including moves and reserved opcodes
        for (int i = 0; i < 40; i++) begin
            op = 3'($urandom_range(0, 7));
            a  = pick_operand();
            b  = pick_operand();
            if (op < 3'd4) begin
                run_md("rnd", op, a, b);
            end else if (op < 3'd6) begin
                run_move("rnd_mv", op, a);
            end else begin
                @(negedge clk);
                issue(op, a, b);
                chk("rnd_rsv_busy", K_busy, 1'b0);
                chk("rnd_rsv_hi", K_hi, exp_hi);
                chk("rnd_rsv_lo", K_lo, exp_lo);
                $display("op=%0d reserved -> hi=%h lo=%h", op, K_hi, K_lo);
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
